// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receive path: pin synchronisation, ps2_clk deglitch filter,
// 11-bit frame deframer with odd-parity check and frame timeout, and
// E0/F0 prefix decode into per-key extended/break qualifiers.
module ps2_keyboard_rx #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       key_valid,
  output logic       extended,
  output logic       break_code
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          bit_in;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          ext_flag;
  logic          brk_flag;

  // Two-flop synchronisers for both asynchronous pins (idle level is high).
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Deglitch ps2_clk: flip the filtered level only after FILTER_LEN consecutive
  // differing samples; emit a one-cycle fall strobe with the data bit aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      bit_in   <= 1'b1;
    end else begin
      fall   <= 1'b0;
      bit_in <= data_sync[1];
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame deframer, timeout and prefix decode; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      data       <= 8'h00;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      key_valid  <= 1'b0;
      extended   <= 1'b0;
      break_code <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle; the branches below raise
      // them for exactly the one cycle their event occurs.
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      key_valid  <= 1'b0;

      case (state)
        IDLE: begin
          if (fall && !bit_in) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (fall) begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
        end
        PARITY: begin
          if (fall) begin
            par_bit <= bit_in;
            state   <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state <= IDLE;
            if (bit_in) begin
              data       <= shreg;
              data_valid <= 1'b1;
              parity_err <= ~^{shreg, par_bit};
              if (^{shreg, par_bit}) begin
                if (shreg == CODE_EXT) begin
                  ext_flag <= 1'b1;
                end else if (shreg == CODE_BRK) begin
                  brk_flag <= 1'b1;
                end else begin
                  key_valid  <= 1'b1;
                  extended   <= ext_flag;
                  break_code <= brk_flag;
                  ext_flag   <= 1'b0;
                  brk_flag   <= 1'b0;
                end
              end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Inter-edge watchdog; a detected edge always restarts it.
      if (state == IDLE) begin
        tcnt <= '0;
      end else if (fall) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tcnt      <= '0;
        state     <= IDLE;
        frame_err <= 1'b1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: table of whole frames with expected
// results, plus hand sequences for timeout and mid-frame reset.
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN = 4;
  localparam int TIMEOUT    = 400;
  localparam int HALF       = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       data_valid, parity_err, frame_err, key_valid, extended, break_code;

  ps2_keyboard_rx #(
    .CLK_FREQ      (50_000_000),
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data      (data),
    .data_valid(data_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .key_valid (key_valid),
    .extended  (extended),
    .break_code(break_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       stop;
    int         glitch_bit;
    int         exp_dv;
    int         exp_fe;
    int         exp_kv;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ext;
    logic       exp_brk;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Pulse monitor, sampled on the falling clock edge.
  int   dv_cnt = 0;
  int   fe_cnt = 0;
  int   kv_cnt = 0;
  logic dv_perr = 1'b0;
  logic kv_ext  = 1'b0;
  logic kv_brk  = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt  = dv_cnt + 1;
      dv_perr = parity_err;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (key_valid) begin
      kv_cnt = kv_cnt + 1;
      kv_ext = extended;
      kv_brk = break_code;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive n frame bits LSB first; data changes while ps2_clk is high.
  // Optionally inject sub-filter-length low glitches on ps2_clk at bit gbit.
  task automatic send_bits(input logic [10:0] f, input int n, input int gbit);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      tick(HALF / 2);
      if (i == gbit) begin
        for (int g = 1; g < FILTER_LEN; g++) begin
          ps2_clk = 1'b0;
          tick(g);
          ps2_clk = 1'b1;
          tick(10);
        end
      end
      tick(HALF / 2);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input logic bad_par,
                                             input logic stop);
    return {stop, (~^code) ^ bad_par, code, 1'b0};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int dv0, fe0, kv0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    kv0 = kv_cnt;
    send_bits(make_frame(v.code, v.bad_par, v.stop), 11, v.glitch_bit);
    tick(30);
    check({tag, ".data_valid_pulses"}, dv_cnt - dv0, v.exp_dv);
    check({tag, ".frame_err_pulses"}, fe_cnt - fe0, v.exp_fe);
    check({tag, ".key_valid_pulses"}, kv_cnt - kv0, v.exp_kv);
    check({tag, ".data"}, data, v.exp_data);
    if (v.exp_dv > 0) check({tag, ".parity_err"}, dv_perr, v.exp_perr);
    if (v.exp_kv > 0) begin
      check({tag, ".extended"}, kv_ext, v.exp_ext);
      check({tag, ".break_code"}, kv_brk, v.exp_brk);
      check({tag, ".extended_held"}, extended, v.exp_ext);
      check({tag, ".break_code_held"}, break_code, v.exp_brk);
    end
  endtask

  vec_t vecs[10];
  vec_t v1c;

  initial begin
    int dv0, fe0;

    //          code   badp stop glit dv fe kv data   perr ext brk
    vecs[0] = '{8'h45, 1'b0, 1'b1, -1, 1, 0, 1, 8'h45, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h45, 1'b1, 1'b1, -1, 1, 0, 0, 8'h45, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b1, -1, 1, 0, 0, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h1C, 1'b0, 1'b1, -1, 1, 0, 1, 8'h1C, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'hE0, 1'b0, 1'b1, -1, 1, 0, 0, 8'hE0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hF0, 1'b0, 1'b1, -1, 1, 0, 0, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h75, 1'b0, 1'b1, -1, 1, 0, 1, 8'h75, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{8'h1C, 1'b0, 1'b1, -1, 1, 0, 1, 8'h1C, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{8'h33, 1'b0, 1'b0, -1, 0, 1, 0, 8'h1C, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{8'hA6, 1'b0, 1'b1,  3, 1, 0, 1, 8'hA6, 1'b0, 1'b0, 1'b0};
    v1c     = '{8'h1C, 1'b0, 1'b1, -1, 1, 0, 1, 8'h1C, 1'b0, 1'b0, 1'b0};

    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(2);
    check("reset.data", data, 8'h00);
    check("reset.data_valid", data_valid, 1'b0);
    check("reset.parity_err", parity_err, 1'b0);
    check("reset.frame_err", frame_err, 1'b0);
    check("reset.key_valid", key_valid, 1'b0);
    check("reset.extended", extended, 1'b0);
    check("reset.break_code", break_code, 1'b0);
    tick(20);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      tick(20);
    end

    // Partial frame then ps2_clk parked high: watchdog aborts the frame.
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 4, -1);
    tick(TIMEOUT + 200);
    check("timeout.frame_err_pulses", fe_cnt - fe0, 1);
    check("timeout.data_valid_pulses", dv_cnt - dv0, 0);
    check("timeout.data_held", data, 8'hA6);
    run_vec(v1c, "after_timeout");
    tick(20);

    // Arm the break flag, start a frame, reset mid-frame: everything clears.
    send_bits(make_frame(8'hF0, 1'b0, 1'b1), 11, -1);
    tick(20);
    send_bits(make_frame(8'h55, 1'b0, 1'b1), 5, -1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("midreset.data", data, 8'h00);
    check("midreset.key_valid", key_valid, 1'b0);
    check("midreset.extended", extended, 1'b0);
    check("midreset.break_code", break_code, 1'b0);
    tick(20);
    run_vec(v1c, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
